// File: rtl/uart_tx_switch_pkg.sv
// uart_tx_switch_pkg: shared state encoding and default timing for uart_tx_switch.
// The GUARD state exists only when UART_TX_SWITCH_GUARD_EN is defined.
package uart_tx_switch_pkg;
    localparam int DEF_BAUD_PERIOD = 208;
    localparam int DEF_IDLE_BITS   = 10;
    localparam int DEF_GUARD_BITS  = 2;
`ifdef UART_TX_SWITCH_GUARD_EN
    typedef enum logic [1:0] {PASS, WAIT_IDLE, GUARD} state_t;
`else
    typedef enum logic [0:0] {PASS, WAIT_IDLE} state_t;
`endif
endpackage

// File: rtl/uart_idle_detector.sv
// uart_idle_detector: saturating run-length counter of consecutive 1s; o_tc flags the
// cycle that completes a run of TC ones.
module uart_idle_detector #(
    parameter int TC = 40
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_din,
    output logic o_tc
);
    localparam int W = $clog2(TC + 1);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk)
        if (i_rst || !i_en || !i_din) r_cnt <= '0;
        else if (r_cnt != W'(TC)) r_cnt <= r_cnt + 1'b1;
    assign o_tc = i_en && i_din && (r_cnt == W'(TC - 1));
endmodule

// File: rtl/uart_tx_switch.sv
// uart_tx_switch: glitch-free TXD source switch that hands over only after the old source idles.
// Define UART_TX_SWITCH_GUARD_EN to add a forced-idle GUARD period after each handover.
module uart_tx_switch
    import uart_tx_switch_pkg::*;
#(
    parameter int BAUD_PERIOD = DEF_BAUD_PERIOD,
    parameter int IDLE_BITS   = DEF_IDLE_BITS,
    parameter int GUARD_BITS  = DEF_GUARD_BITS
) (
    input  logic clk,
    input  logic sync_reset,
    input  logic uart_tx_cpu,
    input  logic uart_tx_ocd,
    input  logic debug_uart_tx_sel_ocd1_cpu0,
    output logic TXD,
    output logic active_sel_ocd1_cpu0,
    output logic switch_pending
);
    if (GUARD_BITS < 0) $error("GUARD_BITS must be non-negative");
    state_t r_state, w_state_nxt;
    logic r_active, w_active_nxt, r_txd, w_txd_nxt, w_src, w_idle_tc, w_mismatch;
    assign w_src      = r_active ? uart_tx_ocd : uart_tx_cpu;
    assign w_mismatch = debug_uart_tx_sel_ocd1_cpu0 != r_active;
    uart_idle_detector #(.TC(IDLE_BITS * BAUD_PERIOD)) u_idle (
        .clk   (clk),
        .i_rst (sync_reset),
        .i_en  (r_state == WAIT_IDLE),
        .i_din (w_src),
        .o_tc  (w_idle_tc)
    );
`ifdef UART_TX_SWITCH_GUARD_EN
    if (GUARD_BITS < 1) $error("GUARD_BITS must be at least 1 with the guard enabled");
    localparam int GW = $clog2(GUARD_BITS * BAUD_PERIOD + 1);
    logic [GW-1:0] r_guard_cnt;
    logic          w_guard_done;
    always_ff @(posedge clk)
        if (sync_reset || r_state != GUARD) r_guard_cnt <= '0;
        else r_guard_cnt <= r_guard_cnt + 1'b1;
    assign w_guard_done = r_guard_cnt == GW'(GUARD_BITS * BAUD_PERIOD - 1);
`endif
    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active;
        w_txd_nxt    = w_src;
        if (r_state == PASS) begin
            if (w_mismatch) w_state_nxt = WAIT_IDLE;
        end else if (r_state == WAIT_IDLE) begin
            if (!w_mismatch) w_state_nxt = PASS;
            else if (w_idle_tc) begin
                w_active_nxt = !r_active;
`ifdef UART_TX_SWITCH_GUARD_EN
                w_state_nxt  = GUARD;
`else
                w_state_nxt  = PASS;
`endif
            end
        end
`ifdef UART_TX_SWITCH_GUARD_EN
        else begin
            w_txd_nxt = 1'b1;
            if (w_guard_done) w_state_nxt = PASS;
        end
`endif
    end
    always_ff @(posedge clk)
        if (sync_reset) begin
            r_state  <= PASS;
            r_active <= 1'b0;
            r_txd    <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= w_active_nxt;
            r_txd    <= w_txd_nxt;
        end
    assign TXD                  = r_txd;
    assign active_sel_ocd1_cpu0 = r_active;
    assign switch_pending       = r_state == WAIT_IDLE;
endmodule

// File: tb/tb_uart_tx_switch.sv
// tb_uart_tx_switch: directed scoreboard bench for uart_tx_switch (BAUD_PERIOD=4, IDLE_BITS=10).
// Guard-period expectations apply when UART_TX_SWITCH_GUARD_EN is defined.
module tb_uart_tx_switch;
    logic clk = 1'b0;
    logic sync_reset, cpu, ocd, sel;
    logic txd, act, pend;
    int   n_cmp = 0;
    int   n_err = 0;
    typedef struct {
        logic  txd;
        logic  act;
        logic  pend;
        string tag;
    } exp_t;
    exp_t q[$];
    always #5 clk = ~clk;
    uart_tx_switch #(.BAUD_PERIOD(4), .IDLE_BITS(10), .GUARD_BITS(2)) dut (
        .clk                         (clk),
        .sync_reset                  (sync_reset),
        .uart_tx_cpu                 (cpu),
        .uart_tx_ocd                 (ocd),
        .debug_uart_tx_sel_ocd1_cpu0 (sel),
        .TXD                         (txd),
        .active_sel_ocd1_cpu0        (act),
        .switch_pending              (pend)
    );
    task automatic check(input string tag, input string what, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s.%s observed=%b expected=%b", tag, what, obs, exp);
        end
    endtask
    task automatic cyc(input logic r, input logic c, input logic o, input logic s,
                       input logic e_t, input logic e_a, input logic e_p, input string tag);
        exp_t e;
        sync_reset = r;
        cpu        = c;
        ocd        = o;
        sel        = s;
        q.push_back('{e_t, e_a, e_p, tag});
        @(posedge clk);
        #1;
        e = q.pop_front();
        check(e.tag, "TXD", txd, e.txd);
        check(e.tag, "active", act, e.act);
        check(e.tag, "pending", pend, e.pend);
    endtask
    initial begin
        logic fr[6];
        fr = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        cyc(1, 0, 0, 0, 1, 0, 0, "reset");
        cyc(0, 0, 1, 0, 0, 0, 0, "pass_cpu0");
        cyc(0, 1, 0, 0, 1, 0, 0, "pass_cpu1");
        cyc(0, 1, 0, 1, 1, 0, 1, "req_ocd");
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 1, 1, 0, 1, "wait20");
        cyc(0, 1, 0, 0, 1, 0, 0, "req_back");
        cyc(0, 0, 1, 0, 0, 0, 0, "back_pass");
        cyc(0, 0, 1, 1, 0, 0, 1, "midframe_req");
        for (int i = 0; i < 6; i++) cyc(0, fr[i], 0, 1, fr[i], 0, 1, "midframe");
        for (int i = 0; i < 39; i++) cyc(0, 1, 0, 1, 1, 0, 1, "idle39");
        cyc(0, 1, 0, 1, 1, 1, 0, "handover");
`ifdef UART_TX_SWITCH_GUARD_EN
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 1, 1, 0, "guard");
`endif
        cyc(0, 1, 0, 1, 0, 1, 0, "ocd0");
        cyc(0, 0, 1, 1, 1, 1, 0, "ocd1");
        cyc(0, 1, 0, 1, 0, 1, 0, "ocd0b");
        cyc(1, 0, 0, 0, 1, 0, 0, "reset2");
        cyc(0, 1, 0, 1, 1, 0, 1, "req2");
        for (int i = 0; i < 39; i++) cyc(0, 1, 0, 1, 1, 0, 1, "run39");
        cyc(0, 0, 0, 1, 0, 0, 1, "late_zero");
        for (int i = 0; i < 39; i++) cyc(0, 1, 0, 1, 1, 0, 1, "rerun39");
        cyc(0, 1, 0, 1, 1, 1, 0, "handover2");
        cyc(1, 0, 0, 0, 1, 0, 0, "reset3");
        cyc(0, 1, 0, 1, 1, 0, 1, "req3");
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 1, 0, 1, "wait5");
        cyc(1, 0, 0, 1, 1, 0, 0, "reset_mid_wait");
        cyc(0, 0, 1, 1, 0, 0, 1, "post_reset_req");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
